// File: rtl/calc_result_display.sv
// Captures C/Flag on a Done rising edge, converts to 5 BCD digits in 17 cycles, scans an 8-digit active-low display.
// Build option LEADING_ZERO_BLANK_EN blanks leading zero digits 4..1; digit 0 is always shown.
module calc_result_display #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] C,
  input  logic        Flag,
  input  logic        Done,
  output logic        Busy,
  output logic [19:0] Bcd,
  output logic [7:0]  An,
  output logic        Ca,
  output logic        Cb,
  output logic        Cc,
  output logic        Cd,
  output logic        Ce,
  output logic        Cf,
  output logic        Cg,
  output logic        Dp
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0110000;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_UPDATE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_done_d;
  logic              w_capture;
  logic              w_load;
  logic              w_shift;
  logic              w_commit;
  logic [35:0]       r_shift;
  logic [35:0]       w_adj;
  logic [3:0]        r_iter;
  logic              r_flag;
  logic [19:0]       r_bcd;
  logic              r_disp_flag;
  logic [CNT_W-1:0]  r_scan_cnt;
  logic [2:0]        r_digit;
  logic              w_wrap;
  logic              r_slot_start;
  logic [3:0]        w_nib;
  logic              w_show;
  logic [6:0]        w_seg;
  logic [7:0]        r_an;
  logic [6:0]        r_seg;

  function automatic logic [6:0] f_seg(input logic [3:0] i_nib);
    case (i_nib)
      4'd0:    f_seg = 7'b0000001;
      4'd1:    f_seg = 7'b1001111;
      4'd2:    f_seg = 7'b0010010;
      4'd3:    f_seg = 7'b0000110;
      4'd4:    f_seg = 7'b1001100;
      4'd5:    f_seg = 7'b0100100;
      4'd6:    f_seg = 7'b0100000;
      4'd7:    f_seg = 7'b0001111;
      4'd8:    f_seg = 7'b0000000;
      4'd9:    f_seg = 7'b0000100;
      default: f_seg = SEG_BLANK;
    endcase
  endfunction

  assign w_capture = Done & ~r_done_d;

  // ---------------- Conversion FSM ----------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A capture edge in any state (re)starts the conversion; latest value wins.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_capture) begin
          w_load      = 1'b1;
          w_state_nxt = S_CONVERT;
        end
      end
      S_CONVERT: begin
        if (w_capture) begin
          w_load      = 1'b1;
          w_state_nxt = S_CONVERT;
        end else begin
          w_shift = 1'b1;
          if (r_iter == 4'd15) begin
            w_state_nxt = S_UPDATE;
          end
        end
      end
      S_UPDATE: begin
        if (w_capture) begin
          w_load      = 1'b1;
          w_state_nxt = S_CONVERT;
        end else begin
          w_commit    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_adj = r_shift;
    for (int k = 0; k < 5; k++) begin
      if (r_shift[16 + 4*k +: 4] >= 4'd5) begin
        w_adj[16 + 4*k +: 4] = r_shift[16 + 4*k +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_done_d    <= 1'b0;
      r_shift     <= 36'h0;
      r_iter      <= 4'd0;
      r_flag      <= 1'b0;
      r_bcd       <= 20'h0;
      r_disp_flag <= 1'b0;
    end else begin
      r_done_d <= Done;
      if (w_load) begin
        r_shift <= {20'h0, C};
        r_flag  <= Flag;
        r_iter  <= 4'd0;
      end else if (w_shift) begin
        r_shift <= w_adj << 1;
        r_iter  <= r_iter + 4'd1;
      end
      if (w_commit) begin
        r_bcd       <= r_shift[35:16];
        r_disp_flag <= r_flag;
      end
    end
  end

  assign Busy = (r_state != S_IDLE);
  assign Bcd  = r_bcd;

  // ---------------- Display scan ----------------
  assign w_wrap = (r_scan_cnt == CNT_MAX);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_scan_cnt   <= '0;
      r_digit      <= 3'd0;
      r_slot_start <= 1'b1;
    end else begin
      r_slot_start <= w_wrap;
      if (w_wrap) begin
        r_scan_cnt <= '0;
        r_digit    <= r_digit + 3'd1;
      end else begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_nib  = 4'h0;
    w_show = 1'b0;
    w_seg  = SEG_BLANK;
    case (r_digit)
      3'd0: begin w_nib = r_bcd[3:0];   w_show = 1'b1; end
      3'd1: begin w_nib = r_bcd[7:4];   w_show = 1'b1; end
      3'd2: begin w_nib = r_bcd[11:8];  w_show = 1'b1; end
      3'd3: begin w_nib = r_bcd[15:12]; w_show = 1'b1; end
      3'd4: begin w_nib = r_bcd[19:16]; w_show = 1'b1; end
      default: w_show = 1'b0;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    case (r_digit)
      3'd1: if (r_bcd[19:4]  == 16'h0) w_show = 1'b0;
      3'd2: if (r_bcd[19:8]  == 12'h0) w_show = 1'b0;
      3'd3: if (r_bcd[19:12] == 8'h0)  w_show = 1'b0;
      3'd4: if (r_bcd[19:16] == 4'h0)  w_show = 1'b0;
      default: ;
    endcase
`endif
    if (w_show) begin
      w_seg = f_seg(w_nib);
    end
    if (r_digit == 3'd7 && r_disp_flag) begin
      w_show = 1'b1;
      w_seg  = SEG_E;
    end
  end

  // Outputs load only at the first cycle of a slot so a digit never tears mid-dwell.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_an  <= 8'hFF;
      r_seg <= SEG_BLANK;
    end else if (r_slot_start) begin
      r_an  <= w_show ? ~(8'h01 << r_digit) : 8'hFF;
      r_seg <= w_show ? w_seg : SEG_BLANK;
    end
  end

  assign An = r_an;
  assign {Ca, Cb, Cc, Cd, Ce, Cf, Cg} = r_seg;
  assign Dp = 1'b1;

endmodule
